waveform_spike_gen: RTL and testbench

WAVEFORM_SPIKE_GEN -- requirements
Module: waveform_spike_gen

---
 rtl/spike_gen_pkg.sv | 23 ++
 rtl/sat_counter.sv | 30 +++
 rtl/waveform_spike_gen.sv | 121 ++++++++++++
 tb/tb_waveform_spike_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_gen_pkg.sv
// Shared definitions for the waveform spike generator.
//   state_t        : generator FSM states (IDLE, RUN, REFRACT)
//   DEF_*          : default parameter values used by the generator and counter
//   refr_cnt_w()   : width of the refractory down-counter for a given length
package spike_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  localparam int DEF_ACC_W      = 32;
  localparam int DEF_REF_CYCLES = 16;
  localparam int DEF_CNT_W      = 16;

  // The counter holds REF_CYCLES-1 at most; keep at least one bit so a
  // zero-length refractory setting still elaborates.
  function automatic int refr_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : synchronous clear, wins over a simultaneous increment
//   inc          : add one (holds at all-ones once saturated)
//   count        : current count, CNT_W bits
module sat_counter #(
  parameter int CNT_W = spike_gen_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/waveform_spike_gen.sv
// Phase-accumulator spike generator driven by a waveform rate sample.
// Each RUN cycle adds the latched rate to the accumulator; a carry-out is a
// fire event that produces a one-cycle registered spike and, when
// REF_CYCLES > 0, a refractory period with the accumulator frozen.
//   clk, reset_n  : clock and asynchronous active-low reset
//   enable        : run when high; low forces IDLE and clears the accumulator
//   sample_valid  : strobe that latches sample_data as the new rate
//   sample_data   : unsigned rate increment, ACC_W bits
//   count_clear   : synchronous clear of spike_count (ignored without counter)
//   spike         : one-cycle spike pulse
//   refractory    : registered decode of the REFRACT state
//   spike_count   : saturating spike total, only with WAVEFORM_SPIKE_COUNT_EN
// Build option: define WAVEFORM_SPIKE_COUNT_EN to include the spike counter.
module waveform_spike_gen
  import spike_gen_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int REF_CYCLES = DEF_REF_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [ACC_W-1:0] sample_data,
  input  logic             count_clear,
  output logic             spike,
  output logic             refractory
`ifdef WAVEFORM_SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0] spike_count
`endif
);

  localparam int RC_W = refr_cnt_w(REF_CYCLES);
  localparam logic [RC_W-1:0] REF_LOAD =
    (REF_CYCLES > 0) ? RC_W'(REF_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  rate_q;
  logic [RC_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W:0]    sum;
  logic              fire;

  // Next-state / accumulate stage
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, rate_q};
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // Keep the wrapped residue so the average spike rate tracks rate_q.
          acc_d = sum[ACC_W-1:0];
          fire  = sum[ACC_W];
          if (fire && (REF_CYCLES > 0)) begin
            state_d = ST_REFRACT;
            cnt_d   = REF_LOAD;
          end
        end
        ST_REFRACT: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - RC_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      rate_q     <= '0;
      cnt_q      <= '0;
      spike      <= 1'b0;
      refractory <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      spike      <= fire;
      refractory <= enable && (state_q == ST_REFRACT);
      if (sample_valid) begin
        rate_q <= sample_data;
      end
    end
  end

`ifdef WAVEFORM_SPIKE_COUNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (count_clear),
    .inc    (spike),
    .count  (spike_count)
  );
`else
  logic unused_count_clear;
  assign unused_count_clear = count_clear;
`endif

endmodule

// File: tb/tb_waveform_spike_gen.sv
module tb_waveform_spike_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        count_clear;

  logic spike0, refr0, spike4, refr4;
`ifdef WAVEFORM_SPIKE_COUNT_EN
  logic [15:0] cnt0, cnt4;
  logic        spikec, refrc;
  logic [3:0]  cntc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  waveform_spike_gen #(.ACC_W(32), .REF_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .count_clear(count_clear),
    .spike(spike0), .refractory(refr0)
`ifdef WAVEFORM_SPIKE_COUNT_EN
    , .spike_count(cnt0)
`endif
  );

  waveform_spike_gen #(.ACC_W(32), .REF_CYCLES(4), .CNT_W(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .count_clear(count_clear),
    .spike(spike4), .refractory(refr4)
`ifdef WAVEFORM_SPIKE_COUNT_EN
    , .spike_count(cnt4)
`endif
  );

`ifdef WAVEFORM_SPIKE_COUNT_EN
  waveform_spike_gen #(.ACC_W(32), .REF_CYCLES(0), .CNT_W(4)) dutc (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .count_clear(count_clear),
    .spike(spikec), .refractory(refrc), .spike_count(cntc)
  );
`endif

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n      = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    count_clear  = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_rate(input logic [31:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    sample_data = '0; count_clear = 1'b0;
    #1;
    n_cmp++; if (spike0 !== 1'b0) begin n_bad++; $display("FAIL reset_spike0 got %b want 0", spike0); end
    n_cmp++; if (spike4 !== 1'b0) begin n_bad++; $display("FAIL reset_spike4 got %b want 0", spike4); end
    n_cmp++; if (refr4 !== 1'b0) begin n_bad++; $display("FAIL reset_refr4 got %b want 0", refr4); end
    n_cmp++; if (refr0 !== 1'b0) begin n_bad++; $display("FAIL reset_refr0 got %b want 0", refr0); end
`ifdef WAVEFORM_SPIKE_COUNT_EN
    n_cmp++; if (cntc !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cntc); end
`endif
    tick(); tick();
    reset_n = 1'b1;
    // enable low: rate is latched but nothing runs
    load_rate(32'hFFFF_FFFF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (spike4 !== 1'b0) begin n_bad++; $display("FAIL disabled_spike k=%0d got %b want 0", k, spike4); end
    end
  endtask

  task automatic test_rate_half();
    int nspk;
    logic exp;
    nspk = 0;
    apply_reset();
    load_rate(32'h8000_0000);
    enable = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k >= 3) begin
        exp = (k % 2 == 1);
        if (spike0 === 1'b1) nspk++;
        n_cmp++; if (spike0 !== exp) begin n_bad++; $display("FAIL half_rate k=%0d got %b want %b", k, spike0, exp); end
      end
    end
    n_cmp++; if (nspk !== 8) begin n_bad++; $display("FAIL half_rate_count got %0d want 8", nspk); end
  endtask

  task automatic test_refractory();
    logic es, er;
    apply_reset();
    load_rate(32'hFFFF_FFFF);
    enable = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      es = (k == 3) || (k == 8) || (k == 13);
      er = (k >= 4 && k <= 7) || (k >= 9 && k <= 12);
      n_cmp++; if (spike4 !== es) begin n_bad++; $display("FAIL refr_spike k=%0d got %b want %b", k, spike4, es); end
      n_cmp++; if (refr4 !== er) begin n_bad++; $display("FAIL refr_flag k=%0d got %b want %b", k, refr4, er); end
    end
  endtask

  task automatic test_late_strobe();
    logic es;
    apply_reset();
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++; if ((spike0 | spike4) !== 1'b0) begin n_bad++; $display("FAIL zero_rate k=%0d got %b%b want 00", k, spike0, spike4); end
    end
    load_rate(32'h4000_0000);
    n_cmp++; if (spike4 !== 1'b0) begin n_bad++; $display("FAIL strobe_k1 got %b want 0", spike4); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      es = (k == 5);
      n_cmp++; if (spike4 !== es) begin n_bad++; $display("FAIL strobe_spike4 k=%0d got %b want %b", k, spike4, es); end
      n_cmp++; if (spike0 !== es) begin n_bad++; $display("FAIL strobe_spike0 k=%0d got %b want %b", k, spike0, es); end
    end
  endtask

  task automatic test_enable_drop();
    logic es;
    apply_reset();
    load_rate(32'hFFFF_FFFF);
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    n_cmp++; if (refr4 !== 1'b1) begin n_bad++; $display("FAIL drop_pre_refr got %b want 1", refr4); end
    enable = 1'b0;
    tick();
    n_cmp++; if (refr4 !== 1'b0) begin n_bad++; $display("FAIL drop_refr got %b want 0", refr4); end
    n_cmp++; if (dut4.acc_q !== 32'h0) begin n_bad++; $display("FAIL drop_acc got %h want 0", dut4.acc_q); end
    n_cmp++; if (dut4.state_q !== spike_gen_pkg::ST_IDLE) begin n_bad++; $display("FAIL drop_state got %0d want %0d", dut4.state_q, spike_gen_pkg::ST_IDLE); end
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      es = (k == 3);
      n_cmp++; if (spike4 !== es) begin n_bad++; $display("FAIL restart_spike k=%0d got %b want %b", k, spike4, es); end
      n_cmp++; if (refr4 !== (k == 4)) begin n_bad++; $display("FAIL restart_refr k=%0d got %b want %b", k, refr4, (k == 4)); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    load_rate(32'hFFFF_FFFF);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    n_cmp++; if (spike0 !== 1'b1) begin n_bad++; $display("FAIL areset_pre_spike got %b want 1", spike0); end
    n_cmp++; if (refr4 !== 1'b1) begin n_bad++; $display("FAIL areset_pre_refr got %b want 1", refr4); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (spike0 !== 1'b0) begin n_bad++; $display("FAIL areset_spike0 got %b want 0", spike0); end
    n_cmp++; if (refr4 !== 1'b0) begin n_bad++; $display("FAIL areset_refr4 got %b want 0", refr4); end
    n_cmp++; if (spike4 !== 1'b0) begin n_bad++; $display("FAIL areset_spike4 got %b want 0", spike4); end
    #1 reset_n = 1'b1;
    tick();
    n_cmp++; if ((spike0 | spike4 | refr4) !== 1'b0) begin n_bad++; $display("FAIL areset_after got %b%b%b want 000", spike0, spike4, refr4); end
  endtask

`ifdef WAVEFORM_SPIKE_COUNT_EN
  task automatic test_counter();
    apply_reset();
    load_rate(32'hFFFF_FFFF);
    enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 17) begin
        n_cmp++; if (cntc !== 4'd14) begin n_bad++; $display("FAIL count_k17 got %0d want 14", cntc); end
      end
      if (k == 18 || k == 24) begin
        n_cmp++; if (cntc !== 4'd15) begin n_bad++; $display("FAIL count_sat k=%0d got %0d want 15", k, cntc); end
      end
    end
    n_cmp++; if (spikec !== 1'b1) begin n_bad++; $display("FAIL clear_pre_spike got %b want 1", spikec); end
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    n_cmp++; if (cntc !== 4'd0) begin n_bad++; $display("FAIL count_clear got %0d want 0", cntc); end
    tick();
    n_cmp++; if (cntc !== 4'd1) begin n_bad++; $display("FAIL count_after_clear got %0d want 1", cntc); end
  endtask
`endif

  initial begin
    test_reset();
    test_rate_half();
    test_refractory();
    test_late_strobe();
    test_enable_drop();
    test_async_reset();
`ifdef WAVEFORM_SPIKE_COUNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
